// File: rtl/recorder_key_ctrl.sv
// Recorder user-command front end: key sync/debounce, mode FSM, playback speed latch.
// Define RECORDER_KEY_CLEAR_EN to debounce key[3] and let it clear the recording from HOLD.
module recorder_key_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DEB_W      = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_key,
    input  logic [17:0] i_sw,
    input  logic        i_mem_full,
    input  logic        i_play_done,
    output logic [2:0]  o_state,
    output logic        o_speed_fast,
    output logic [3:0]  o_speed_factor,
    output logic        o_start_rec,
    output logic        o_start_play
);

`ifdef RECORDER_KEY_CLEAR_EN
    localparam int unsigned NKEY = 4;
`else
    localparam int unsigned NKEY = 3;
    logic unused_key_clr;
    assign unused_key_clr = i_key[3];
`endif
    localparam int unsigned SWW = 8;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_REC   = 3'd2,
        S_PLAY  = 3'd3,
        S_PAUSE = 3'd4
    } state_e;

    logic unused_sw;
    assign unused_sw = ^{i_sw[16:9], i_sw[1:0]};

    // Two-flop synchronizers; vld_q marks when the sync chain holds real input samples.
    logic [NKEY-1:0] key_s1_q, key_s2_q;
    logic [SWW-1:0]  sw_s1_q, sw_s2_q;
    logic [1:0]      vld_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            vld_q    <= '0;
        end else begin
            key_s1_q <= i_key[NKEY-1:0];
            key_s2_q <= key_s1_q;
            sw_s1_q  <= {i_sw[17], i_sw[8:2]};
            sw_s2_q  <= sw_s1_q;
            vld_q    <= {vld_q[0], 1'b1};
        end
    end

    // Debounce; a key only arms once seen released, so a key held through reset is ignored.
    logic [NKEY-1:0]  acc_q, acc_d, armed_q, armed_d, press_q, press_d;
    logic [DEB_W-1:0] cnt_q [NKEY];
    logic [DEB_W-1:0] cnt_d [NKEY];

    always_comb begin
        acc_d   = acc_q;
        armed_d = armed_q;
        press_d = '0;
        for (int k = 0; k < NKEY; k++) begin
            cnt_d[k] = '0;
            if (key_s2_q[k] != acc_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    acc_d[k] = key_s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
            if (vld_q[1] && key_s2_q[k]) begin
                armed_d[k] = 1'b1;
            end
            press_d[k] = armed_q[k] & acc_q[k] & ~acc_d[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '1;
            armed_q <= '0;
            press_q <= '0;
            for (int k = 0; k < NKEY; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            acc_q   <= acc_d;
            armed_q <= armed_d;
            press_q <= press_d;
            for (int k = 0; k < NKEY; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Same-cycle presses: stop beats record beats play.
    logic stop_p, rec_p, play_p, clr_p;
    assign stop_p = press_q[2];
    assign rec_p  = press_q[0] & ~press_q[2];
    assign play_p = press_q[1] & ~press_q[2] & ~press_q[0];
`ifdef RECORDER_KEY_CLEAR_EN
    assign clr_p  = press_q[3] & ~press_q[2];
`else
    assign clr_p  = 1'b0;
`endif

    logic [3:0] factor_dec;
    always_comb begin
        factor_dec = 4'd1;
        for (int i = 2; i <= 8; i++) begin
            if (sw_s2_q[i-2]) begin
                factor_dec = 4'(i);
            end
        end
    end

    state_e     state_q, state_d;
    logic       start_rec_q, start_rec_d, start_play_q, start_play_d;
    logic       fast_q, fast_d;
    logic [3:0] factor_q, factor_d;

    always_comb begin
        state_d  = state_q;
        fast_d   = fast_q;
        factor_d = factor_q;
        case (state_q)
            S_IDLE:  if (rec_p) state_d = S_REC;
            S_REC:   if (i_mem_full || stop_p || rec_p) state_d = S_HOLD;
            S_HOLD: begin
                if (play_p)     state_d = S_PLAY;
                else if (rec_p) state_d = S_REC;
                else if (clr_p) state_d = S_IDLE;
            end
            S_PLAY: begin
                if (i_play_done || stop_p) state_d = S_HOLD;
                else if (play_p)           state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (stop_p)      state_d = S_HOLD;
                else if (play_p) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
        start_rec_d  = (state_d == S_REC) && (state_q != S_REC);
        start_play_d = (state_q == S_HOLD) && (state_d == S_PLAY);
        // Speed follows the switches only while paused and at the moment playback starts.
        if (((state_d == S_PLAY) && (state_q != S_PLAY)) || (state_q == S_PAUSE)) begin
            fast_d   = sw_s2_q[7];
            factor_d = factor_dec;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            start_rec_q  <= 1'b0;
            start_play_q <= 1'b0;
            fast_q       <= 1'b1;
            factor_q     <= 4'd1;
        end else begin
            state_q      <= state_d;
            start_rec_q  <= start_rec_d;
            start_play_q <= start_play_d;
            fast_q       <= fast_d;
            factor_q     <= factor_d;
        end
    end

    assign o_state        = state_q;
    assign o_speed_fast   = fast_q;
    assign o_speed_factor = factor_q;
    assign o_start_rec    = start_rec_q;
    assign o_start_play   = start_play_q;

endmodule

// File: tb/tb_recorder_key_ctrl.sv
// Bench for recorder_key_ctrl: directed vector table plus random keys against a behavioural model.
module tb_recorder_key_ctrl;
    localparam int DEB = 4;
    localparam int DW  = 4;
`ifdef RECORDER_KEY_CLEAR_EN
    localparam int NK  = 4;
    localparam int CLR = 1;
`else
    localparam int NK  = 3;
    localparam int CLR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key;
    logic [17:0] sw;
    logic        mf, pd;
    logic [2:0]  o_state;
    logic        o_speed_fast;
    logic [3:0]  o_speed_factor;
    logic        o_start_rec, o_start_play;

    always #5 clk = ~clk;

    recorder_key_ctrl #(.DEB_CYCLES(DEB), .DEB_W(DW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_key         (key),
        .i_sw          (sw),
        .i_mem_full    (mf),
        .i_play_done   (pd),
        .o_state       (o_state),
        .o_speed_fast  (o_speed_fast),
        .o_speed_factor(o_speed_factor),
        .o_start_rec   (o_start_rec),
        .o_start_play  (o_start_play)
    );

    int total = 0;
    int bad   = 0;
    int nrec, nplay;
    bit mchk = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: keys/switches are seen two clocks late; a level is accepted after
    // DEB consecutive synced samples disagree with it; an accepted press acts one clock later.
    int          m_mode, m_fac, m_edges;
    bit          m_fast, m_srec, m_splay;
    logic [3:0]  m_acc, m_armed, m_prs;
    logic [3:0]  m_rawk[$];
    logic [17:0] m_rsw[$];
    logic [3:0]  m_synk[$];

    task automatic model_reset();
        m_mode = 0; m_fac = 1; m_fast = 1'b1; m_srec = 1'b0; m_splay = 1'b0;
        m_acc = 4'hF; m_armed = 4'h0; m_prs = 4'h0; m_edges = 0;
        m_rawk = {4'hF, 4'hF};
        m_rsw  = {18'h0, 18'h0};
        m_synk = {};
    endtask

    task automatic model_step();
        logic [3:0]  syn, prs_new;
        logic [17:0] ssw;
        int nw;
        bit stop_p, rec_p, play_p, clr_p, all_diff;
        m_edges++;
        m_rawk.push_back(key);
        m_rsw.push_back(sw);
        syn = m_rawk[m_rawk.size()-3];
        ssw = m_rsw[m_rsw.size()-3];
        m_synk.push_back(syn);
        stop_p = m_prs[2];
        rec_p  = m_prs[0] && !stop_p;
        play_p = m_prs[1] && !stop_p && !m_prs[0];
        clr_p  = m_prs[3] && !stop_p;
        nw = m_mode;
        case (m_mode)
            0: if (rec_p) nw = 2;
            2: if (mf || stop_p || rec_p) nw = 1;
            1: if (play_p) nw = 3; else if (rec_p) nw = 2; else if (clr_p) nw = 0;
            3: if (pd || stop_p) nw = 1; else if (play_p) nw = 4;
            4: if (stop_p) nw = 1; else if (play_p) nw = 3;
            default: nw = 0;
        endcase
        if ((nw == 3 && m_mode != 3) || m_mode == 4) begin
            m_fast = ssw[17];
            m_fac  = 1;
            for (int i = 2; i <= 8; i++) if (ssw[i]) m_fac = i;
        end
        m_srec  = (nw == 2 && m_mode != 2);
        m_splay = (m_mode == 1 && nw == 3);
        m_mode  = nw;
        prs_new = 4'h0;
        for (int k = 0; k < NK; k++) begin
            if (m_synk.size() >= DEB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (m_synk[m_synk.size()-1-j][k] == m_acc[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    prs_new[k] = m_acc[k] & m_armed[k];
                    m_acc[k]   = ~m_acc[k];
                end
            end
            if (m_edges >= 3 && syn[k]) m_armed[k] = 1'b1;
        end
        m_prs = prs_new;
        while (m_rawk.size() > 4) void'(m_rawk.pop_front());
        while (m_rsw.size() > 4) void'(m_rsw.pop_front());
        while (m_synk.size() > 8) void'(m_synk.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (o_start_rec)  nrec++;
        if (o_start_play) nplay++;
        if (mchk) begin
            chk("m_state",  int'(o_state), m_mode);
            chk("m_fast",   int'(o_speed_fast), int'(m_fast));
            chk("m_factor", int'(o_speed_factor), m_fac);
            chk("m_srec",   int'(o_start_rec), int'(m_srec));
            chk("m_splay",  int'(o_start_play), int'(m_splay));
        end
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [17:0] sw;
        bit          mf;
        bit          pd;
        int          n;
        int          st;
        int          fast;
        int          fac;
        int          nrec;
        int          nplay;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [3:0] k, input logic [17:0] s, input bit f, input bit p,
                                input int n, input int st, input int fa, input int fc,
                                input int nr, input int np);
        vec_t v;
        v.key = k; v.sw = s; v.mf = f; v.pd = p; v.n = n;
        v.st = st; v.fast = fa; v.fac = fc; v.nrec = nr; v.nplay = np;
        tbl.push_back(v);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] sw5, sw85;
        sw5  = 18'h00020;
        sw85 = 18'h00120;
        rst_n = 1'b0; key = 4'hF; sw = 18'h0; mf = 1'b0; pd = 1'b0;
        nrec = 0; nplay = 0;

        repeat (3) @(negedge clk);
        chk("rst_state",  int'(o_state), 0);
        chk("rst_fast",   int'(o_speed_fast), 1);
        chk("rst_factor", int'(o_speed_factor), 1);
        chk("rst_srec",   int'(o_start_rec), 0);
        chk("rst_splay",  int'(o_start_play), 0);
        rst_n = 1'b1;
        model_reset();
        mchk = 1'b1;
        repeat (5) tick();

        // Two-cycle glitch on record must be rejected
        key = 4'hE;
        repeat (2) tick();
        key = 4'hF;
        repeat (8) tick();
        chk("glitch_state", int'(o_state), 0);
        chk("glitch_srec", nrec, 0);

        // Clean record press: REC exactly 7 clocks after the falling edge
        key = 4'hE;
        repeat (6) tick();
        chk("lat6_state", int'(o_state), 0);
        tick();
        chk("lat7_state", int'(o_state), 2);
        chk("lat7_srec", int'(o_start_rec), 1);
        tick();
        chk("lat8_srec", int'(o_start_rec), 0);
        repeat (2) tick();
        key = 4'hF;
        repeat (8) tick();
        chk("rec_state", int'(o_state), 2);
        chk("rec_npulse", nrec, 1);

        add(4'hF, 18'h0, 1, 0, 1, 1, 1, 1, 0, 0);
        add(4'hF, sw5,   0, 0, 3, 1, 1, 1, 0, 0);
        add(4'hD, sw5,   0, 0, 6, 1, 1, 1, 0, 0);
        add(4'hF, sw5,   0, 0, 8, 3, 0, 5, 0, 1);
        add(4'hF, sw85,  0, 0, 8, 3, 0, 5, 0, 0);
        add(4'hD, sw85,  0, 0, 6, 3, 0, 5, 0, 0);
        add(4'hF, sw85,  0, 0, 8, 4, 0, 8, 0, 0);
        add(4'hD, sw85,  0, 0, 6, 4, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 0, 8, 3, 0, 8, 0, 0);
        add(4'h9, sw85,  0, 0, 6, 3, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 0, 8, 1, 0, 8, 0, 0);
        add(4'hD, sw85,  0, 0, 6, 1, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 0, 8, 3, 0, 8, 0, 1);
        add(4'hD, sw85,  0, 0, 6, 3, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 1, 1, 1, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 0, 8, 1, 0, 8, 0, 0);
        add(4'h7, sw85,  0, 0, 6, 1, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 0, 8, (CLR != 0) ? 0 : 1, 0, 8, 0, 0);
        add(4'hE, sw85,  0, 0, 6, (CLR != 0) ? 0 : 1, 0, 8, 0, 0);
        add(4'hF, sw85,  0, 0, 8, 2, 0, 8, 1, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            key = tbl[r].key; sw = tbl[r].sw; mf = tbl[r].mf; pd = tbl[r].pd;
            nrec = 0; nplay = 0;
            repeat (tbl[r].n) tick();
            chk($sformatf("row%0d_state", r),  int'(o_state), tbl[r].st);
            chk($sformatf("row%0d_fast", r),   int'(o_speed_fast), tbl[r].fast);
            chk($sformatf("row%0d_factor", r), int'(o_speed_factor), tbl[r].fac);
            chk($sformatf("row%0d_nrec", r),   nrec, tbl[r].nrec);
            chk($sformatf("row%0d_nplay", r),  nplay, tbl[r].nplay);
        end
        mf = 1'b0; pd = 1'b0;

        // Asynchronous reset mid-REC with record held through reset
        #2;
        rst_n = 1'b0;
        key = 4'hE;
        #1;
        chk("async_state", int'(o_state), 0);
        chk("async_srec",  int'(o_start_rec), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        nrec = 0;
        repeat (20) tick();
        chk("held_state", int'(o_state), 0);
        chk("held_srec", nrec, 0);
        key = 4'hF;
        repeat (10) tick();
        key = 4'hE;
        repeat (6) tick();
        key = 4'hF;
        repeat (8) tick();
        chk("repress_state", int'(o_state), 2);
        chk("repress_srec", nrec, 1);

        // Random key/switch/status activity against the model
        for (int s = 0; s < 450; s++) begin
            int r, n;
            r = int'($urandom_range(0, 9));
            if (r < 5)       key = 4'hF;
            else if (r < 9)  key = ~(4'b0001 << $urandom_range(0, 3));
            else             key = 4'($urandom);
            if ($urandom_range(0, 3) == 0) sw = 18'($urandom);
            n = int'($urandom_range(1, 9));
            for (int c = 0; c < n; c++) begin
                mf = ($urandom_range(0, 15) == 0);
                pd = ($urandom_range(0, 15) == 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recorder_key_ctrl.md
Name: recorder_key_ctrl

Overview:
- User-command front end for the audio recorder: debounces the push-buttons, runs the recorder mode FSM and latches the playback speed from the slide switches.
- Produces the 3-bit mode code and the speed setting that the seven-segment/LED display and the audio datapath consume.
- Sits between the board keys/switches and the recorder core; the core reports memory-full and playback-done back into it.

Parameters:
- DEB_CYCLES, 500000, cycles a key must be stable before a level change is accepted (10 ms at 50 MHz); minimum 2.
- DEB_W, 20, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_key  input  4  raw board keys, active-low (0 = pressed); [0]=record, [1]=play/pause, [2]=stop, [3]=clear
- i_sw  input  18  raw slide switches; [17]=fast(1)/slow(0), [8:2]=speed select
- i_mem_full  input  1  level from core: SRAM address reached end during record
- i_play_done  input  1  level from core: playback reached recorded length
- o_state  output  3  mode code: 0 IDLE, 1 HOLD, 2 REC, 3 PLAY, 4 PAUSE
- o_speed_fast  output  1  latched speed direction, 1 = fast
- o_speed_factor  output  4  latched speed factor, 1..8
- o_start_rec  output  1  one-cycle pulse on entry to REC (core resets write address)
- o_start_play  output  1  one-cycle pulse on entry to PLAY from HOLD (core resets read address)

Behaviour:
- Reset (async, i_rst_n=0): o_state=IDLE, o_speed_fast=1, o_speed_factor=1, pulses 0, debouncers report released, counters 0.
- Input sync: i_key passes through a 2-flop synchronizer before debouncing; i_sw is synchronized likewise.
- Debounce, per key: counter clears whenever the synced input equals the accepted level. Otherwise it counts up; when it reaches DEB_CYCLES-1 the accepted level flips.
- Press pulse: one cycle on the accepted 1->0 transition. Latency from a clean press is 2 (sync) + DEB_CYCLES + 1 cycles. Releases generate nothing.
- Simultaneous press pulses in one cycle: priority stop > record > play; the lower-priority pulses are dropped.
- Speed decode: factor = 8 if sw[8], else 7 if sw[7], ... else 2 if sw[2], else 1. fast = sw[17].
- Speed latch: speed is loaded on every transition into PLAY and on every cycle while in PAUSE. It is frozen in all other states, so a switch change during PLAY has no effect until a pause/resume.
- FSM transitions (evaluated each cycle, one transition max):
  - IDLE: record -> REC; play and stop ignored.
  - REC: stop, record or i_mem_full -> HOLD.
  - HOLD: play -> PLAY; record -> REC (overwrites the recording).
  - PLAY: play -> PAUSE; stop -> HOLD; i_play_done -> HOLD.
  - PAUSE: play -> PLAY (no o_start_play pulse); stop -> HOLD.
- Priority within a state:
  - i_mem_full and i_play_done beat key pulses in the same cycle.
  - i_play_done while in PAUSE is ignored.
- Pulse timing: o_start_rec and o_start_play are registered and asserted in the first cycle o_state shows the new mode.
- Illegal o_state encodings (5-7) recover to IDLE on the next clock.
- Reset mid-operation: immediate return to IDLE with no pulses; a key held through reset must be released and pressed again.

Optional Feature:
- Macro: RECORDER_KEY_CLEAR_EN.
- Defined: a debounced i_key[3] press in HOLD -> IDLE, discarding the recording. It has priority below stop and is ignored in other states.
- Undefined: i_key[3] is not debounced and has no effect; its debouncer logic is not instantiated.

Test Plan:
- Bench runs with DEB_CYCLES=4.
- Reset with i_key=4'hF, i_sw=0 -> o_state=0, o_speed_fast=1, o_speed_factor=1, no pulses.
- key[0] low for 10 cycles from IDLE -> o_state=2 exactly 7 cycles after the falling edge, o_start_rec high for 1 cycle. key[0] glitching low for 2 cycles -> no change.
- In REC assert i_mem_full -> HOLD next cycle. Set i_sw[17]=0, i_sw[5]=1 and press play -> o_state=3, o_start_play pulse, o_speed_fast=0, o_speed_factor=5.
- In PLAY set i_sw[8]=1 -> factor stays 5. Press play -> PAUSE and factor becomes 8. Press play -> PLAY with no o_start_play pulse.
- In PLAY press stop and play in the same cycle -> HOLD. Assert i_play_done with a play press in PLAY -> HOLD.
- Drop i_rst_n mid-REC -> o_state=0 asynchronously. With RECORDER_KEY_CLEAR_EN, key[3] in HOLD -> IDLE; without it -> stays HOLD.
